// File: rtl/pcie_lane_rx_aligner.sv
// rtl/pcie_lane_rx_aligner.sv - single-lane 8b10b serial receiver with K28.5 symbol alignment
// Optional statistics outputs (CommaCount, RealignCount) are enabled by PCIE_RX_ALIGN_STATS_EN.
module pcie_lane_rx_aligner #(
  parameter int unsigned LockCommas   = 2,
  parameter int unsigned UnlockCommas = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        SerIn,
  input  logic        ElecIdleIn,
  output logic [9:0]  SymOut,
  output logic        SymValid,
  output logic        SymIsComma,
  output logic        Locked,
  output logic        LockLost
`ifdef PCIE_RX_ALIGN_STATS_EN
  ,
  output logic [15:0] CommaCount,
  output logic [7:0]  RealignCount
`endif
);

  localparam logic [3:0] LockTarget   = 4'(LockCommas);
  localparam logic [3:0] UnlockTarget = 4'(UnlockCommas);
  localparam logic [9:0] CommaNeg     = 10'h17C;
  localparam logic [9:0] CommaPos     = 10'h283;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CONFIRM,
    ST_LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  sr_q, sr_d;
  logic [3:0]  phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  mis_q, mis_d;
  logic [9:0]  sym_out_q, sym_out_d;
  logic        sym_valid_q, sym_valid_d;
  logic        sym_is_comma_q, sym_is_comma_d;
  logic        locked_q, locked_d;
  logic        lock_lost_q, lock_lost_d;

  logic        comma_now;
  logic        boundary;
  logic        realign;
  logic        entering_lock;

  // Shift the serial bit in (held during idle) and detect a K28.5 in the updated window.
  always_comb begin
    sr_d      = sr_q;
    if (!ElecIdleIn) begin
      sr_d = {SerIn, sr_q[9:1]};
    end
    comma_now = !ElecIdleIn && ((sr_d == CommaNeg) || (sr_d == CommaPos));
    boundary  = (phase_q == 4'd9);
  end

  // Alignment FSM: hunt for a comma, confirm the phase, then track misaligned commas.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    realign = 1'b0;
    if (ElecIdleIn) begin
      state_d = ST_HUNT;
      cnt_d   = 4'd0;
      mis_d   = 4'd0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (comma_now) begin
            realign = 1'b1;
            cnt_d   = 4'd1;
            state_d = (LockTarget <= 4'd1) ? ST_LOCKED : ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (comma_now && boundary) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) >= LockTarget) begin
              state_d = ST_LOCKED;
              mis_d   = 4'd0;
            end
          end else if (comma_now) begin
            realign = 1'b1;
            cnt_d   = 4'd1;
            if (LockTarget <= 4'd1) begin
              state_d = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (comma_now && boundary) begin
            mis_d = 4'd0;
          end else if (comma_now) begin
            if ((mis_q + 4'd1) >= UnlockTarget) begin
              state_d = ST_CONFIRM;
              realign = 1'b1;
              cnt_d   = 4'd1;
              mis_d   = 4'd0;
            end else begin
              mis_d = mis_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          cnt_d   = 4'd0;
          mis_d   = 4'd0;
        end
      endcase
    end
  end

  // Bit-phase counter: restarts on a newly accepted comma, wraps at the symbol boundary, frozen in idle.
  always_comb begin
    phase_d = phase_q;
    if (!ElecIdleIn) begin
      if (realign || boundary) begin
        phase_d = 4'd0;
      end else begin
        phase_d = phase_q + 4'd1;
      end
    end
  end

  // Registered symbol outputs; the locking comma itself is presented together with the Locked rise.
  always_comb begin
    entering_lock  = (state_q != ST_LOCKED) && (state_d == ST_LOCKED);
    sym_valid_d    = !ElecIdleIn && (((state_q == ST_LOCKED) && boundary) || entering_lock);
    sym_out_d      = sym_valid_d ? sr_d : sym_out_q;
    sym_is_comma_d = sym_valid_d ? comma_now : sym_is_comma_q;
    locked_d       = (state_d == ST_LOCKED);
    lock_lost_d    = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
  end

  // State and output registers; reset wins over everything and never produces a LockLost pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_HUNT;
      sr_q           <= '0;
      phase_q        <= '0;
      cnt_q          <= '0;
      mis_q          <= '0;
      sym_out_q      <= '0;
      sym_valid_q    <= 1'b0;
      sym_is_comma_q <= 1'b0;
      locked_q       <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      mis_q          <= mis_d;
      sym_out_q      <= sym_out_d;
      sym_valid_q    <= sym_valid_d;
      sym_is_comma_q <= sym_is_comma_d;
      locked_q       <= locked_d;
      lock_lost_q    <= lock_lost_d;
    end
  end

  assign SymOut     = sym_out_q;
  assign SymValid   = sym_valid_q;
  assign SymIsComma = sym_is_comma_q;
  assign Locked     = locked_q;
  assign LockLost   = lock_lost_q;

`ifdef PCIE_RX_ALIGN_STATS_EN
  logic [15:0] comma_count_q, comma_count_d;
  logic [7:0]  realign_count_q, realign_count_d;

  // Saturating counters of presented commas and lock losses, taken from the registered strobes.
  always_comb begin
    comma_count_d   = comma_count_q;
    realign_count_d = realign_count_q;
    if (sym_valid_q && sym_is_comma_q && !(&comma_count_q)) begin
      comma_count_d = comma_count_q + 16'd1;
    end
    if (lock_lost_q && !(&realign_count_q)) begin
      realign_count_d = realign_count_q + 8'd1;
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      comma_count_q   <= '0;
      realign_count_q <= '0;
    end else begin
      comma_count_q   <= comma_count_d;
      realign_count_q <= realign_count_d;
    end
  end

  assign CommaCount   = comma_count_q;
  assign RealignCount = realign_count_q;
`endif

endmodule

// File: tb/tb_pcie_lane_rx_aligner.sv
// tb/tb_pcie_lane_rx_aligner.sv - scoreboard bench for pcie_lane_rx_aligner
module tb_pcie_lane_rx_aligner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       SerIn;
  logic       ElecIdleIn;
  logic [9:0] SymOut;
  logic       SymValid;
  logic       SymIsComma;
  logic       Locked;
  logic       LockLost;
`ifdef PCIE_RX_ALIGN_STATS_EN
  logic [15:0] CommaCount;
  logic [7:0]  RealignCount;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_evt = 0;
  int exp_commas = 0;
  int exp_losts  = 0;

  typedef struct {
    bit         is_lost;
    logic [9:0] sym;
    bit         comma;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  pcie_lane_rx_aligner #(
    .LockCommas(2),
    .UnlockCommas(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .SerIn(SerIn),
    .ElecIdleIn(ElecIdleIn),
    .SymOut(SymOut),
    .SymValid(SymValid),
    .SymIsComma(SymIsComma),
    .Locked(Locked),
    .LockLost(LockLost)
`ifdef PCIE_RX_ALIGN_STATS_EN
    ,
    .CommaCount(CommaCount),
    .RealignCount(RealignCount)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic tick_bit(input logic b, input logic idle);
    SerIn      = b;
    ElecIdleIn = idle;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) begin
      tick_bit(s[i], 1'b0);
    end
  endtask

  // Filler bits 1,0,1,0,1 in time order; used to place commas off the boundary.
  task automatic send_fill();
    for (int i = 0; i < 5; i++) begin
      tick_bit(((i & 1) == 0) ? 1'b1 : 1'b0, 1'b0);
    end
  endtask

  task automatic exp_sym(input logic [9:0] s, input bit c, input int gap);
    exp_t e;
    e.is_lost = 1'b0;
    e.sym     = s;
    e.comma   = c;
    e.gap     = gap;
    exp_q.push_back(e);
    if (c) exp_commas++;
  endtask

  task automatic exp_lost(input int gap);
    exp_t e;
    e.is_lost = 1'b1;
    e.sym     = 10'h000;
    e.comma   = 1'b0;
    e.gap     = gap;
    exp_q.push_back(e);
    exp_losts++;
  endtask

  // Monitor: every SymValid or LockLost strobe must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge Clk);
      if (SymValid || LockLost) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event cyc=%0d actual valid=%0b lost=%0b sym=0x%0h required none",
                   cyc, SymValid, LockLost, SymOut);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_lost", int'(LockLost), int'(mon_e.is_lost));
          check("event_is_valid", int'(SymValid), int'(!mon_e.is_lost));
          if (!mon_e.is_lost) begin
            check("sym_data", int'(SymOut), int'(mon_e.sym));
            check("sym_is_comma", int'(SymIsComma), int'(mon_e.comma));
            check("locked_with_sym", int'(Locked), 1);
          end else begin
            check("locked_at_lost", int'(Locked), 0);
          end
          if (mon_e.gap > 0) begin
            check("event_gap", cyc - last_evt, mon_e.gap);
          end
        end
        last_evt = cyc;
      end
    end
  end

  initial begin
    Reset      = 1'b1;
    SerIn      = 1'b0;
    ElecIdleIn = 1'b0;

    // Reset held 5 cycles with a toggling serial input.
    for (int i = 0; i < 5; i++) begin
      tick_bit(((i & 1) == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    check("reset_symvalid", int'(SymValid), 0);
    check("reset_locked", int'(Locked), 0);
    check("reset_symout", int'(SymOut), 0);
    check("reset_locklost", int'(LockLost), 0);
    check("reset_symiscomma", int'(SymIsComma), 0);
    Reset = 1'b0;

    // Junk, comma, data, comma: lock on the second comma.
    for (int i = 0; i < 3; i++) tick_bit(1'b0, 1'b0);
    exp_sym(10'h283, 1'b1, 0);
    send_sym(10'h17C);
    send_sym(10'h1B5);
    check("locked_before_second_comma", int'(Locked), 0);
    send_sym(10'h283);
    check("locked_after_second_comma", int'(Locked), 1);
    check("symvalid_with_lock", int'(SymValid), 1);
    exp_sym(10'h1B5, 1'b0, 10);
    send_sym(10'h1B5);
    exp_sym(10'h17C, 1'b1, 10);
    send_sym(10'h17C);

    // One inserted bit, then five commas: lost after the 4th, relocked on the 5th.
    for (int k = 0; k < 4; k++) exp_sym(10'h2F8, 1'b0, 10);
    exp_lost(1);
    exp_sym(10'h17C, 1'b1, 10);
    tick_bit(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_sym(10'h17C);
    check("relocked_new_phase", int'(Locked), 1);
    exp_sym(10'h1B5, 1'b0, 10);
    send_sym(10'h1B5);

    // Misaligned comma, aligned comma, then three misaligned commas: lock is kept.
    exp_sym(10'h395, 1'b0, 10);
    exp_sym(10'h2AB, 1'b0, 10);
    exp_sym(10'h17C, 1'b1, 10);
    send_fill();
    send_sym(10'h17C);
    send_fill();
    send_sym(10'h17C);
    for (int k = 0; k < 3; k++) begin
      exp_sym(10'h395, 1'b0, 10);
      exp_sym(10'h2AB, 1'b0, 10);
      send_fill();
      send_sym(10'h17C);
      send_fill();
    end
    check("locked_after_misaligned", int'(Locked), 1);

    // Electrical idle for 7 cycles mid-symbol, then two aligned commas relock.
    tick_bit(1'b1, 1'b0);
    tick_bit(1'b0, 1'b0);
    tick_bit(1'b1, 1'b0);
    tick_bit(1'b0, 1'b0);
    exp_lost(5);
    for (int j = 0; j < 7; j++) begin
      tick_bit(((j & 1) == 0) ? 1'b1 : 1'b0, 1'b1);
      if (j == 0) begin
        check("idle_locked", int'(Locked), 0);
        check("idle_locklost", int'(LockLost), 1);
      end
    end
    check("idle_end_locked", int'(Locked), 0);
    exp_sym(10'h17C, 1'b1, 26);
    send_sym(10'h17C);
    check("idle_one_comma_locked", int'(Locked), 0);
    send_sym(10'h17C);
    check("idle_relocked", int'(Locked), 1);

`ifdef PCIE_RX_ALIGN_STATS_EN
    // Repeated forced realigns to drive RealignCount into saturation.
    for (int r = 0; r < 300; r++) begin
      for (int k = 0; k < 4; k++) exp_sym(10'h2F8, 1'b0, 10);
      exp_lost(1);
      exp_sym(10'h17C, 1'b1, 10);
      tick_bit(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) send_sym(10'h17C);
    end
`endif

    tick_bit(1'b0, 1'b0);
    tick_bit(1'b0, 1'b0);

`ifdef PCIE_RX_ALIGN_STATS_EN
    check("stats_comma_count", int'(CommaCount), exp_commas);
    check("stats_realign_count", int'(RealignCount), (exp_losts > 255) ? 255 : exp_losts);
`endif

    // Reset while locked: lock drops with no LockLost pulse.
    Reset = 1'b1;
    tick_bit(1'b0, 1'b0);
    check("midreset_locked", int'(Locked), 0);
    check("midreset_locklost", int'(LockLost), 0);
    check("midreset_symvalid", int'(SymValid), 0);
    Reset = 1'b0;
    tick_bit(1'b0, 1'b0);
    tick_bit(1'b0, 1'b0);
    check("midreset_no_locklost", int'(LockLost), 0);
    check("expected_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
